traffic_light_controller: RTL and testbench
===========================================

# traffic_light_controller

Free-running single-approach traffic light sequencer. It cycles RED → GREEN → YELLOW → RED, holding each phase for a parameterised number of clock cycles, and drives three lamp outputs. It is a standalone Moore FSM with a phase counter and no external handshake. It sits at the lamp-driver boundary: outputs go directly to lamp enables.

## Interface
- RED_CYCLES, 10: clock cycles the RED phase lasts; legal range ≥1; a value of 0 is treated as 1.
- GREEN_CYCLES, 8: clock cycles the GREEN phase lasts; legal range ≥1; 0 is treated as 1.
- YELLOW_CYCLES, 3: clock cycles the YELLOW phase lasts; legal range ≥1; 0 is treated as 1.
- RED_YELLOW_CYCLES, 2: clock cycles of the RED_YELLOW phase; used only with TLC_RED_YELLOW_EN; 0 is treated as 1.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- red  output  1  red lamp enable, active-high.
- green  output  1  green lamp enable, active-high.
- yellow  output  1  yellow lamp enable, active-high.

## Operation
- State register with states RED, GREEN, YELLOW, plus RED_YELLOW when TLC_RED_YELLOW_EN is defined.
- Phase counter width is $clog2 of the largest duration, minimum 1 bit; unused encodings are unreachable.
- Any unreachable or illegal state encoding recovers to RED with the counter at 0 on the next edge.
- Reset asserted (reset=0): state = RED and count = 0 immediately, without waiting for a clock edge. Outputs become red=1, green=0, yellow=0.
- Each rising edge while reset=1:
  - If count == DUR(state)-1: go to the next state and set count = 0.
  - Otherwise: count = count + 1.
- Transitions: RED→GREEN, GREEN→YELLOW, YELLOW→RED. With the macro defined, RED→RED_YELLOW→GREEN replaces RED→GREEN.
- Outputs are a pure decode of the state register (Moore), so no combinational path exists from inputs to outputs and there are no glitches:
  - RED: 100 (red, green, yellow)
  - GREEN: 010
  - YELLOW: 001
  - RED_YELLOW: 101
- Invariant: green is never high at the same time as red or yellow. Without the macro, exactly one output is high at all times.

## Timing
- Latency from reset release to the first state change: exactly RED_CYCLES rising edges.
- Each phase occupies exactly DUR rising edges. Outputs change only right after a rising edge, or asynchronously on reset assertion.
- Full period: RED_CYCLES+GREEN_CYCLES+YELLOW_CYCLES cycles, plus RED_YELLOW_CYCLES with the macro (21 cycles at defaults).
- Reset asserted mid-phase, in any state: red is forced immediately and the count cleared. Sequencing restarts from a full RED phase after release.
- Reset released on the same edge as a clock rise: that edge is ignored and counting starts at the next edge.
- Duration of 1: the phase lasts exactly one cycle, and the counter stays at 0.

## Configuration
- TLC_RED_YELLOW_EN defined: a RED_YELLOW phase (red=1, yellow=1, green=0) of RED_YELLOW_CYCLES is inserted between RED and GREEN.
- Not defined: there is no RED_YELLOW state. The RED_YELLOW_CYCLES parameter is accepted but ignored, and the one-hot output invariant holds.

## Test plan
- Hold reset=0 for 7 cycles, then release → red=1, green=0, yellow=0 throughout reset and for exactly 10 edges after release.
- Run defaults for 2 full periods → per period: 10 cycles red, 8 green, 3 yellow, repeating every 21 cycles; one-hot every cycle.
- Assert reset for 1 ns during GREEN (between edges) → red=1 immediately. After release: a full 10-cycle RED, then GREEN.
- Parameters RED=1, GREEN=1, YELLOW=1 → outputs rotate 100, 010, 001 every cycle with no stalls.
- With TLC_RED_YELLOW_EN and defaults → sequence 10 red, 2 red+yellow (101), 8 green, 3 yellow; period 23 cycles.
- Force an illegal state encoding (e.g. 2'b11 without the macro) → state is RED with count 0 after the next edge.

Source files
------------

// File: rtl/traffic_light_controller.sv
// Free-running RED -> GREEN -> YELLOW lamp sequencer (Moore FSM + phase counter).
// Define TLC_RED_YELLOW_EN to insert a RED_YELLOW phase between RED and GREEN.
module traffic_light_controller #(
  parameter int unsigned RED_CYCLES        = 10,
  parameter int unsigned GREEN_CYCLES      = 8,
  parameter int unsigned YELLOW_CYCLES     = 3,
  parameter int unsigned RED_YELLOW_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic red_o,
  output logic green_o,
  output logic yellow_o
);

  // Zero-length phases are clamped to a single cycle.
  localparam int unsigned RED_DUR    = (RED_CYCLES    == 0) ? 1 : RED_CYCLES;
  localparam int unsigned GREEN_DUR  = (GREEN_CYCLES  == 0) ? 1 : GREEN_CYCLES;
  localparam int unsigned YELLOW_DUR = (YELLOW_CYCLES == 0) ? 1 : YELLOW_CYCLES;
  localparam int unsigned RGY_MAX    = (RED_DUR > GREEN_DUR)
                                       ? ((RED_DUR > YELLOW_DUR) ? RED_DUR : YELLOW_DUR)
                                       : ((GREEN_DUR > YELLOW_DUR) ? GREEN_DUR : YELLOW_DUR);
`ifdef TLC_RED_YELLOW_EN
  localparam int unsigned RY_DUR  = (RED_YELLOW_CYCLES == 0) ? 1 : RED_YELLOW_CYCLES;
  localparam int unsigned MAX_DUR = (RY_DUR > RGY_MAX) ? RY_DUR : RGY_MAX;
`else
  localparam int unsigned MAX_DUR = RGY_MAX;
`endif
  localparam int unsigned CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_DUR - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_DUR - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_DUR - 1);
`ifdef TLC_RED_YELLOW_EN
  localparam logic [CNT_W-1:0] RY_LAST     = CNT_W'(RY_DUR - 1);
`endif

  localparam logic [1:0] ST_RED        = 2'd0;
  localparam logic [1:0] ST_GREEN      = 2'd1;
  localparam logic [1:0] ST_YELLOW     = 2'd2;
`ifdef TLC_RED_YELLOW_EN
  localparam logic [1:0] ST_RED_YELLOW = 2'd3;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: defaults first so every path assigns; also makes illegal encodings fall back to RED/0.
    state_d = ST_RED;
    count_d = '0;
    case (state_q)
      ST_RED: begin
        if (count_q == RED_LAST) begin
`ifdef TLC_RED_YELLOW_EN
          state_d = ST_RED_YELLOW;
`else
          state_d = ST_GREEN;
`endif
        end else begin
          state_d = ST_RED;
          count_d = count_q + CNT_W'(1);
        end
      end
`ifdef TLC_RED_YELLOW_EN
      ST_RED_YELLOW: begin
        if (count_q == RY_LAST) begin
          state_d = ST_GREEN;
        end else begin
          state_d = ST_RED_YELLOW;
          count_d = count_q + CNT_W'(1);
        end
      end
`endif
      ST_GREEN: begin
        if (count_q == GREEN_LAST) begin
          state_d = ST_YELLOW;
        end else begin
          state_d = ST_GREEN;
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_YELLOW: begin
        if (count_q == YELLOW_LAST) begin
          state_d = ST_RED;
        end else begin
          state_d = ST_YELLOW;
          count_d = count_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RED;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Pure decode of the state register; unknown encodings show red until recovered.
  always_comb begin
    red_o    = 1'b1;
    green_o  = 1'b0;
    yellow_o = 1'b0;
    case (state_q)
      ST_GREEN: begin
        red_o   = 1'b0;
        green_o = 1'b1;
      end
      ST_YELLOW: begin
        red_o    = 1'b0;
        yellow_o = 1'b1;
      end
`ifdef TLC_RED_YELLOW_EN
      ST_RED_YELLOW: yellow_o = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller: default, 1-cycle and 0-clamped instances
// checked against a phase-table model through an expected-value queue.
`timescale 1ns/100ps
module tb_traffic_light_controller;

  localparam int R  = 10;
  localparam int G  = 8;
  localparam int Y  = 3;
`ifdef TLC_RED_YELLOW_EN
  localparam int RY = 2;
  localparam int FAST_PERIOD = 4;
`else
  localparam int RY = 0;
  localparam int FAST_PERIOD = 3;
`endif
  localparam int PERIOD = R + RY + G + Y;

  typedef struct {
    string      tag;
    logic [2:0] exp_main;
    logic [2:0] exp_fast;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic red, green, yellow;
  logic red_f, green_f, yellow_f;
  logic red_z, green_z, yellow_z;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  traffic_light_controller dut (
    .clk_i(clk), .rst_ni(rst_n), .red_o(red), .green_o(green), .yellow_o(yellow)
  );

  traffic_light_controller #(
    .RED_CYCLES(1), .GREEN_CYCLES(1), .YELLOW_CYCLES(1), .RED_YELLOW_CYCLES(1)
  ) dut_fast (
    .clk_i(clk), .rst_ni(rst_n), .red_o(red_f), .green_o(green_f), .yellow_o(yellow_f)
  );

  traffic_light_controller #(
    .RED_CYCLES(0), .GREEN_CYCLES(0), .YELLOW_CYCLES(0), .RED_YELLOW_CYCLES(0)
  ) dut_zero (
    .clk_i(clk), .rst_ni(rst_n), .red_o(red_z), .green_o(green_z), .yellow_o(yellow_z)
  );

  // Expected {red,green,yellow} after k edges since reset release, default durations.
  function automatic logic [2:0] main_exp(int k);
    int p;
    p = k % PERIOD;
    if (p < R) return 3'b100;
    p = p - R;
    if (p < RY) return 3'b101;
    p = p - RY;
    if (p < G) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [2:0] fast_exp(int k);
    int p;
    p = k % FAST_PERIOD;
    if (p == 0) return 3'b100;
`ifdef TLC_RED_YELLOW_EN
    if (p == 1) return 3'b101;
    p = p - 1;
`endif
    if (p == 1) return 3'b010;
    return 3'b001;
  endfunction

  task automatic push(string tag, logic [2:0] em, logic [2:0] ef);
    exp_t e;
    e.tag = tag;
    e.exp_main = em;
    e.exp_fast = ef;
    sb_q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    logic [2:0] obs_m, obs_f, obs_z;
    e = sb_q.pop_front();
    obs_m = {red, green, yellow};
    obs_f = {red_f, green_f, yellow_f};
    obs_z = {red_z, green_z, yellow_z};
    checks++;
    assert (obs_m === e.exp_main) else begin
      errors++;
      $error("FAIL %s main: got %b expected %b", e.tag, obs_m, e.exp_main);
    end
    checks++;
    assert (obs_f === e.exp_fast) else begin
      errors++;
      $error("FAIL %s fast: got %b expected %b", e.tag, obs_f, e.exp_fast);
    end
    checks++;
    assert (obs_z === e.exp_fast) else begin
      errors++;
      $error("FAIL %s zero: got %b expected %b", e.tag, obs_z, e.exp_fast);
    end
    checks++;
`ifdef TLC_RED_YELLOW_EN
    assert (!(green && (red || yellow))) else begin
`else
    assert ($onehot(obs_m)) else begin
`endif
      errors++;
      $error("FAIL %s invariant: got %b expected legal lamp combination", e.tag, obs_m);
    end
  endtask

  // Push expectation, let one rising edge pass, compare on the falling edge.
  task automatic cycle(string tag, logic [2:0] em, logic [2:0] ef);
    push(tag, em, ef);
    @(negedge clk);
    compare();
  endtask

  initial begin
    int fk;

    for (int i = 0; i < 7; i++) cycle("in_reset", 3'b100, 3'b100);

    rst_n = 1'b1;
    #1;
    push("release", main_exp(0), fast_exp(0));
    compare();
    @(negedge clk);
    compare_after_release: begin end
    push("run_k1", main_exp(1), fast_exp(1));
    compare();
    for (int k = 2; k <= 2 * PERIOD + 10; k++) cycle("run", main_exp(k), fast_exp(k));

    // Now in GREEN: short asynchronous reset pulse between edges.
    #2 rst_n = 1'b0;
    #1;
    push("async_reset", 3'b100, 3'b100);
    compare();
    rst_n = 1'b1;
    for (int k = 1; k <= R + RY + 2; k++) cycle("after_reset", main_exp(k), fast_exp(k));
    fk = R + RY + 2;

`ifndef TLC_RED_YELLOW_EN
    force dut.state_q = 2'b11;
    #1;
    release dut.state_q;
    fk++;
    cycle("illegal_recover", 3'b100, fast_exp(fk));
    checks++;
    assert (dut.count_q === '0) else begin
      errors++;
      $error("FAIL illegal_count: got %0d expected 0", dut.count_q);
    end
    for (int j = 1; j <= R + 1; j++) begin
      fk++;
      cycle("post_illegal", main_exp(j), fast_exp(fk));
    end
`endif

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
